// File: rtl/calc_input_sequencer.sv
// calc_input_sequencer: key-event front end for the calculator arithmetic unit.
// Registers operand A, operand B and the op select from key events. After
// EQUALS it holds the operands stable for SETTLE_CYCLES cycles, then captures
// the arithmetic unit result and flags divide-by-zero.
// Optional feature macro: CALC_CHAIN_EN (an OP in DONE chains the previous
// result's low nibble in as operand A).
module calc_input_sequencer #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   output logic       key_ready,
   input  logic [1:0] key_type,
   input  logic [3:0] key_data,
   output logic [3:0] op_a,
   output logic [3:0] op_b,
   output logic [1:0] op_sel,
   input  logic [7:0] au_result,
   output logic [7:0] res_out,
   output logic       res_valid,
   output logic       div_zero,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GOT_A  = 3'd1,
      GOT_OP = 3'd2,
      GOT_B  = 3'd3,
      EXEC   = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam logic [1:0] K_DIGIT  = 2'b00;
   localparam logic [1:0] K_OP     = 2'b01;
   localparam logic [1:0] K_EQUALS = 2'b10;
   localparam logic [1:0] K_CLEAR  = 2'b11;
   localparam logic [1:0] OP_DIV   = 2'b11;
   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t     state;
   logic [3:0] settle_cnt;
   logic       key_acc;

   // Keys are refused only while the arithmetic unit is settling.
   assign key_ready = (state != EXEC);
   assign key_acc   = key_valid && key_ready;
   assign state_o   = state;

   // Sequencer FSM: operand/op registers, settle counter and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         op_a       <= 4'd0;
         op_b       <= 4'd0;
         op_sel     <= 2'd0;
         res_out    <= 8'd0;
         res_valid  <= 1'b0;
         div_zero   <= 1'b0;
         settle_cnt <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (key_acc && key_type == K_DIGIT) begin
                  op_a  <= key_data;
                  state <= GOT_A;
               end
            end
            GOT_A: begin
               if (key_acc && key_type == K_DIGIT) begin
                  op_a <= key_data;
               end else if (key_acc && key_type == K_OP) begin
                  op_sel <= key_data[1:0];
                  state  <= GOT_OP;
               end
            end
            GOT_OP: begin
               if (key_acc && key_type == K_DIGIT) begin
                  op_b  <= key_data;
                  state <= GOT_B;
               end else if (key_acc && key_type == K_OP) begin
                  op_sel <= key_data[1:0];
               end
            end
            GOT_B: begin
               if (key_acc && key_type == K_DIGIT) begin
                  op_b <= key_data;
               end else if (key_acc && key_type == K_EQUALS) begin
                  settle_cnt <= CNT_LOAD;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               if (settle_cnt == 4'd0) begin
                  // Divide-by-zero result is forced; the AU output is meaningless then.
                  if (op_sel == OP_DIV && op_b == 4'd0) begin
                     res_out  <= 8'hFF;
                     div_zero <= 1'b1;
                  end else begin
                     res_out  <= au_result;
                     div_zero <= 1'b0;
                  end
                  res_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end
            DONE: begin
               if (key_acc && key_type == K_DIGIT) begin
                  op_a      <= key_data;
                  op_b      <= 4'd0;
                  op_sel    <= 2'd0;
                  res_valid <= 1'b0;
                  state     <= GOT_A;
               end
`ifdef CALC_CHAIN_EN
               else if (key_acc && key_type == K_OP) begin
                  op_a      <= res_out[3:0];
                  op_sel    <= key_data[1:0];
                  op_b      <= 4'd0;
                  res_valid <= 1'b0;
                  state     <= GOT_OP;
               end
`endif
            end
            default: state <= IDLE;
         endcase

         // CLEAR overrides whatever the state branch did (never accepted in EXEC).
         if (key_acc && key_type == K_CLEAR) begin
            state     <= IDLE;
            op_a      <= 4'd0;
            op_b      <= 4'd0;
            op_sel    <= 2'd0;
            res_out   <= 8'd0;
            res_valid <= 1'b0;
            div_zero  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Bench for calc_input_sequencer: unit 0 uses SETTLE_CYCLES=1, unit 1 uses 4.
// A behavioural arithmetic unit feeds au_result; expected results are queued
// when EQUALS is driven and compared when res_valid rises.
module tb_calc_input_sequencer;

   localparam logic [1:0] DIG = 2'b00;
   localparam logic [1:0] OPK = 2'b01;
   localparam logic [1:0] EQ  = 2'b10;
   localparam logic [1:0] CLR = 2'b11;

   logic       clk = 1'b0;
   logic       rst_w     [2];
   logic       kv        [2];
   logic [1:0] kt        [2];
   logic [3:0] kd        [2];
   logic       key_ready_w [2];
   logic [3:0] op_a_w    [2];
   logic [3:0] op_b_w    [2];
   logic [1:0] op_sel_w  [2];
   logic [7:0] au_w      [2];
   logic [7:0] res_out_w [2];
   logic       res_valid_w [2];
   logic       div_zero_w [2];
   logic [2:0] state_w   [2];
   logic       prev_rv   [2];

   logic [8:0] sbq0 [$];
   logic [8:0] sbq1 [$];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   calc_input_sequencer #(.SETTLE_CYCLES(1)) u_seq1 (
      .clk(clk), .rst(rst_w[0]), .key_valid(kv[0]), .key_ready(key_ready_w[0]),
      .key_type(kt[0]), .key_data(kd[0]), .op_a(op_a_w[0]), .op_b(op_b_w[0]),
      .op_sel(op_sel_w[0]), .au_result(au_w[0]), .res_out(res_out_w[0]),
      .res_valid(res_valid_w[0]), .div_zero(div_zero_w[0]), .state_o(state_w[0])
   );

   calc_input_sequencer #(.SETTLE_CYCLES(4)) u_seq4 (
      .clk(clk), .rst(rst_w[1]), .key_valid(kv[1]), .key_ready(key_ready_w[1]),
      .key_type(kt[1]), .key_data(kd[1]), .op_a(op_a_w[1]), .op_b(op_b_w[1]),
      .op_sel(op_sel_w[1]), .au_result(au_w[1]), .res_out(res_out_w[1]),
      .res_valid(res_valid_w[1]), .div_zero(div_zero_w[1]), .state_o(state_w[1])
   );

   // Behavioural arithmetic unit; divide by zero returns junk so the override shows.
   function automatic logic [7:0] au_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] s);
      logic [7:0] r;
      logic [3:0] t;
      case (s)
         2'b00: begin t = a + b; r = {4'h0, t}; end
         2'b01: begin t = a - b; r = {4'h0, t}; end
         2'b10: r = {4'h0, a} * {4'h0, b};
         default: begin
            if (b == 4'd0) r = 8'h5A;
            else begin
               t = a / b;
               r = {t, 4'(a % b)};
            end
         end
      endcase
      return r;
   endfunction

   always_comb begin
      au_w[0] = au_model(op_a_w[0], op_b_w[0], op_sel_w[0]);
      au_w[1] = au_model(op_a_w[1], op_b_w[1], op_sel_w[1]);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic push(input int u, input logic [7:0] res, input logic dz);
      if (u == 0) sbq0.push_back({dz, res});
      else        sbq1.push_back({dz, res});
   endtask

   // Scoreboard: compare on each rising res_valid.
   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (res_valid_w[u] === 1'b1 && prev_rv[u] !== 1'b1) begin
            logic [8:0] e;
            if ((u == 0 && sbq0.size() == 0) || (u == 1 && sbq1.size() == 0)) begin
               chk("unexpected_res", 32'd1, 32'd0);
            end else begin
               e = (u == 0) ? sbq0.pop_front() : sbq1.pop_front();
               chk("res_out", 32'(res_out_w[u]), 32'(e[7:0]));
               chk("div_zero", 32'(div_zero_w[u]), 32'(e[8]));
            end
         end
         prev_rv[u] <= res_valid_w[u];
      end
   end

   // Hold a key until accepted; returns after the accepting edge (+1).
   task automatic press(input int u, input logic [1:0] t, input logic [3:0] d,
                        output int waited);
      logic acc;
      waited = 0;
      kv[u] = 1'b1; kt[u] = t; kd[u] = d;
      forever begin
         @(negedge clk);
         acc = key_ready_w[u];
         @(posedge clk); #1;
         if (acc) break;
         waited++;
         if (waited > 50) begin
            chk("key_accept_timeout", 32'(waited), 32'd0);
            break;
         end
      end
      kv[u] = 1'b0;
   endtask

   task automatic key(input int u, input logic [1:0] t, input logic [3:0] d);
      int w;
      press(u, t, d, w);
   endtask

   task automatic wait_done(input int u);
      int n = 0;
      while (res_valid_w[u] !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("done_timeout", 32'(res_valid_w[u]), 32'd1);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      for (int u = 0; u < 2; u++) begin
         rst_w[u] = 1'b1; kv[u] = 1'b0; kt[u] = 2'b00; kd[u] = 4'd0; prev_rv[u] = 1'b0;
      end
      tick(); tick();
      rst_w[0] = 1'b0; rst_w[1] = 1'b0;
      for (int u = 0; u < 2; u++) begin
         chk("rst_state", 32'(state_w[u]), 32'd0);
         chk("rst_ready", 32'(key_ready_w[u]), 32'd1);
         chk("rst_outs", 32'({op_a_w[u], op_b_w[u], op_sel_w[u], res_out_w[u],
                              res_valid_w[u], div_zero_w[u]}), 32'd0);
      end

      // 7 + 5 with cycle-accurate latency (SETTLE_CYCLES=1)
      key(0, DIG, 4'd7); key(0, OPK, 4'd0); key(0, DIG, 4'd5);
      push(0, 8'h0C, 1'b0);
      key(0, EQ, 4'd0);
      chk("t1_ready_exec", 32'(key_ready_w[0]), 32'd0);
      chk("t1_state_exec", 32'(state_w[0]), 32'd4);
      tick();
      chk("t1_res_valid", 32'(res_valid_w[0]), 32'd1);
      chk("t1_res_out", 32'(res_out_w[0]), 32'h0C);
      chk("t1_state_done", 32'(state_w[0]), 32'd5);

      // OP in DONE: chain or ignore
`ifdef CALC_CHAIN_EN
      key(0, OPK, 4'd0);
      chk("chain_state", 32'(state_w[0]), 32'd2);
      chk("chain_op_a", 32'(op_a_w[0]), 32'hC);
      chk("chain_rv", 32'(res_valid_w[0]), 32'd0);
      key(0, DIG, 4'd3);
      push(0, 8'h0F, 1'b0);
      key(0, EQ, 4'd0);
      wait_done(0);
      chk("chain_op_a_done", 32'(op_a_w[0]), 32'hC);
`else
      key(0, OPK, 4'd0);
      chk("nochain_state", 32'(state_w[0]), 32'd5);
      chk("nochain_res", 32'(res_out_w[0]), 32'h0C);
      chk("nochain_rv", 32'(res_valid_w[0]), 32'd1);
`endif

      // 3-5, 15*15, 13/4
      key(0, DIG, 4'd3); key(0, OPK, 4'd1); key(0, DIG, 4'd5);
      push(0, 8'h0E, 1'b0); key(0, EQ, 4'd0); wait_done(0);
      key(0, DIG, 4'd15); key(0, OPK, 4'd2); key(0, DIG, 4'd15);
      push(0, 8'hE1, 1'b0); key(0, EQ, 4'd0); wait_done(0);
      key(0, DIG, 4'd13); key(0, OPK, 4'hF); key(0, DIG, 4'd4);
      push(0, 8'h31, 1'b0); key(0, EQ, 4'd0); wait_done(0);

      // divide by zero, then a fresh digit from DONE
      key(0, DIG, 4'd9); key(0, OPK, 4'd3); key(0, DIG, 4'd0);
      push(0, 8'hFF, 1'b1); key(0, EQ, 4'd0); wait_done(0);
      key(0, DIG, 4'd2);
      chk("dz_next_state", 32'(state_w[0]), 32'd1);
      chk("dz_next_rv", 32'(res_valid_w[0]), 32'd0);
      chk("dz_next_op_b", 32'(op_b_w[0]), 32'd0);
      chk("dz_next_op_a", 32'(op_a_w[0]), 32'd2);
      chk("dz_hold_res", 32'({div_zero_w[0], res_out_w[0]}), 32'h1FF);

      // overwrite rules, EQUALS ignored in GOT_A, CLEAR held through EXEC
      key(0, CLR, 4'd0);
      key(0, DIG, 4'd4); key(0, DIG, 4'd6);
      key(0, EQ, 4'd0);
      chk("eq_in_got_a", 32'(state_w[0]), 32'd1);
      key(0, OPK, 4'd1); key(0, OPK, 4'd2); key(0, DIG, 4'd3); key(0, DIG, 4'd2);
      push(0, 8'h0C, 1'b0);
      key(0, EQ, 4'd0);
      chk("ovr_op_a", 32'(op_a_w[0]), 32'd6);
      chk("ovr_op_sel", 32'(op_sel_w[0]), 32'd2);
      chk("ovr_op_b", 32'(op_b_w[0]), 32'd2);
      press(0, CLR, 4'd0, w);
      chk("clr_wait", 32'(w), 32'd1);
      chk("clr_state", 32'(state_w[0]), 32'd0);
      chk("clr_outs", 32'({op_a_w[0], op_b_w[0], op_sel_w[0], res_out_w[0],
                           res_valid_w[0], div_zero_w[0]}), 32'd0);

      // SETTLE_CYCLES=4 latency
      key(1, DIG, 4'd7); key(1, OPK, 4'd0); key(1, DIG, 4'd5);
      push(1, 8'h0C, 1'b0);
      key(1, EQ, 4'd0);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("s4_ready_n%0d", i), 32'(key_ready_w[1]), 32'd0);
         chk($sformatf("s4_rv_n%0d", i), 32'(res_valid_w[1]), 32'd0);
         tick();
      end
      chk("s4_rv_n5", 32'(res_valid_w[1]), 32'd1);
      chk("s4_res_n5", 32'(res_out_w[1]), 32'h0C);

      // reset in the middle of EXEC abandons the operation
      key(1, DIG, 4'd3); key(1, OPK, 4'd2); key(1, DIG, 4'd3);
      key(1, EQ, 4'd0);
      tick();
      rst_w[1] = 1'b1;
      tick();
      rst_w[1] = 1'b0;
      chk("abort_state", 32'(state_w[1]), 32'd0);
      chk("abort_outs", 32'({op_a_w[1], op_b_w[1], op_sel_w[1], res_out_w[1],
                             res_valid_w[1], div_zero_w[1]}), 32'd0);
      for (int i = 0; i < 6; i++) tick();
      chk("abort_no_res", 32'(res_valid_w[1]), 32'd0);

      chk("sb0_empty", 32'(sbq0.size()), 32'd0);
      chk("sb1_empty", 32'(sbq1.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
